bcd_convertor_pipe: RTL and testbench
=====================================

# bcd_convertor_pipe

Parametrised binary-to-BCD converter using the double-dabble (shift-and-add-3) method, with valid/ready handshakes on both sides, an overflow flag and optional leading-zero blanking. It generalises the fixed 8-bit, 2-digit converter to any input width and digit count. Every BCD digit is corrected in parallel on each shift. It sits between counters or ADC paths and the 7-segment digit multiplexer.

## Interface
- `DATA_WIDTH`, default 8: binary input width; must be ≥1.
- `DIGITS`, default 3: number of BCD output digits; must be ≥1.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  DATA_WIDTH  unsigned binary value.
- `i_valid`  in  1  `i_data` valid.
- `o_ready`  out  1  converter can accept `i_data`.
- `o_bcd`  out  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- `o_overflow`  out  1  value exceeded 10^DIGITS−1; `o_bcd` then holds value mod 10^DIGITS.
- `o_blank`  out  DIGITS  per-digit leading-zero flag (see Configuration).
- `o_valid`  out  1  `o_bcd`, `o_overflow` and `o_blank` are valid.
- `i_ready`  in  1  downstream accepts the result.

## Operation
- Reset, asynchronous on `i_rst_n` low: state IDLE, scratch 0, shift counter 0, `o_valid`=0, `o_bcd`=0, `o_overflow`=0, `o_blank`=0.
- `o_ready` equals (state==IDLE), so it is 1 immediately after reset.
- States:
  - IDLE: on `i_valid && o_ready`, load `{4*DIGITS zeros, i_data}` into scratch, clear the sticky overflow bit, set counter=DATA_WIDTH, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD digit ≥5 (all digits in parallel), then shift the whole scratch left by 1 and decrement the counter.
    - If the bit shifted out of the top digit is 1, set the sticky overflow bit.
    - When the counter reaches 0 after this shift, go to DONE.
  - DONE: `o_valid`=1. On `i_ready`, go to IDLE.
- Output stability: `o_bcd`, `o_overflow` and `o_blank` are registered and stay stable throughout DONE. They are don't-care outside DONE, but the implementation holds the last result.
- Backpressure:
  - `i_valid` is ignored while `o_ready`=0.
  - Upstream must hold `i_data` only until the accept edge, because data is captured at that edge.
- Overflow: the result is the correct BCD of value mod 10^DIGITS with `o_overflow`=1. Example: DIGITS=2 and input 100 gives 0x00 with overflow.
- Counter width: $clog2(DATA_WIDTH+1) bits. The scratch register is 4*DIGITS+DATA_WIDTH bits wide.

## Timing
- The accept edge is edge k. Shifts occur at edges k+1 through k+DATA_WIDTH.
- `o_valid` goes high after edge k+DATA_WIDTH, giving a latency of DATA_WIDTH cycles.
- After edge k+DATA_WIDTH+n, where n is the first cycle with `i_ready` high: `o_valid`=0 and `o_ready`=1.
- Throughput is one conversion per DATA_WIDTH+2 cycles when `i_ready` is held at 1.
- DATA_WIDTH=1: one shift cycle, then DONE.
- Reset during SHIFT or DONE aborts the conversion with no `o_valid` pulse. After release the block is in IDLE.
- In DONE, `i_valid` has no effect. It is first sampled in IDLE.

## Configuration
- `BCD_BLANK_EN` defined: on entry to DONE, `o_blank[j]`=1 when digit j and all higher digits are 0, for j≥1. `o_blank[0]` is always 0, so a value of 0 shows "0".
  - When `o_overflow`=1, `o_blank` is all 0.
- `BCD_BLANK_EN` undefined: `o_blank` is tied to 0 and no blanking logic is built.

## Test plan
- Defaults (8, 3): input 255, `i_ready`=1 → `o_valid` 8 cycles after accept, `o_bcd`=0x255, `o_overflow`=0.
- Defaults with `BCD_BLANK_EN`: input 0 → `o_bcd`=0x000, `o_blank`=3'b110. Input 7 → `o_blank`=3'b110. Input 42 → `o_blank`=3'b100.
- DIGITS=2: input 99 → 0x99, overflow 0. Input 100 → 0x00, overflow 1. Input 255 → 0x55, overflow 1.
- Backpressure: `i_ready`=0 for 5 cycles in DONE → `o_valid`, `o_bcd` and `o_overflow` stable and `o_ready`=0 throughout; `i_valid` pulses in that window are ignored. Set `i_ready`=1 → IDLE next cycle.
- Reset mid-conversion: drop `i_rst_n` at shift 4 → outputs 0 asynchronously. After release `o_ready`=1, and a new input 123 yields 0x123.
- DATA_WIDTH=16, DIGITS=5: input 65535 → `o_bcd`=0x65535, latency 16 cycles. Back-to-back inputs 1, 10, 100 with `i_ready`=1 → 0x00001, 0x00010, 0x00100 in order.

Source files
------------

// File: rtl/bcd_convertor_pipe.sv
// Parametrised binary-to-BCD converter (double dabble) with valid/ready handshakes on both sides.
// Optional leading-zero blanking is built only when BCD_BLANK_EN is defined.
module bcd_convertor_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIGITS     = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [4*DIGITS-1:0]     o_bcd,
    output logic                    o_overflow,
    output logic [DIGITS-1:0]       o_blank,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_scratch;
    logic [SW-1:0]   w_scratch_nxt;
    logic [SW-1:0]   w_corr;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_ovf;
    logic            w_ovf_nxt;
    logic            w_last;
    logic            r_valid;
    logic            r_ready;
    logic [BW-1:0]   r_bcd;
    logic            r_bcd_ovf;
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank;

    assign w_last = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    // Add-3 correction applied to every BCD digit in parallel
    always_comb begin
        w_corr = r_scratch;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (r_scratch[DATA_WIDTH + 4*j +: 4] >= 4'd5) begin
                w_corr[DATA_WIDTH + 4*j +: 4] = r_scratch[DATA_WIDTH + 4*j +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid)           w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1))   w_state_nxt = S_DONE;
            S_DONE:  if (i_ready)           w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values; the bit leaving the top digit marks overflow
    always_comb begin
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_scratch_nxt = {{BW{1'b0}}, i_data};
                    w_cnt_nxt     = CW'(DATA_WIDTH);
                    w_ovf_nxt     = 1'b0;
                end
            end
            S_SHIFT: begin
                w_scratch_nxt = {w_corr[SW-2:0], 1'b0};
                w_cnt_nxt     = r_cnt - CW'(1);
                w_ovf_nxt     = r_ovf | w_corr[SW-1];
            end
            default: ;
        endcase
    end

`ifdef BCD_BLANK_EN
    logic w_all_zero;

    // Digit j blanks when it and every higher digit are zero; ones digit never blanks
    always_comb begin
        w_blank    = '0;
        w_all_zero = ~w_ovf_nxt;
        for (int j = int'(DIGITS) - 1; j >= 1; j--) begin
            w_all_zero = w_all_zero & (w_scratch_nxt[DATA_WIDTH + 4*j +: 4] == 4'd0);
            w_blank[j] = w_all_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
            r_bcd     <= '0;
            r_bcd_ovf <= 1'b0;
            r_blank   <= '0;
        end else begin
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_valid   <= (w_state_nxt == S_DONE);
            r_ready   <= (w_state_nxt == S_IDLE);
            if (w_last) begin
                r_bcd     <= w_scratch_nxt[SW-1:DATA_WIDTH];
                r_bcd_ovf <= w_ovf_nxt;
                r_blank   <= w_blank;
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_valid    = r_valid;
    assign o_bcd      = r_bcd;
    assign o_overflow = r_bcd_ovf;
    assign o_blank    = r_blank;

endmodule

// File: tb/tb_bcd_convertor_pipe.sv
// Directed bench for bcd_convertor_pipe: three parameterisations (8/3, 8/2, 16/5) sharing clock and reset.
// Blanking expectations follow BCD_BLANK_EN.
module tb_bcd_convertor_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v0, v1, v2, r0, r1, r2;
    logic [7:0]  d0, d1;
    logic [15:0] d2;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic [2:0]  bl0;
    logic [1:0]  bl1;
    logic [4:0]  bl2;

    int n_cmp = 0;
    int n_err = 0;

    bcd_convertor_pipe u_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d0), .i_valid(v0), .o_ready(rdy0),
        .o_bcd(bcd0), .o_overflow(of0), .o_blank(bl0), .o_valid(ov0), .i_ready(r0));
    bcd_convertor_pipe #(.DATA_WIDTH(8), .DIGITS(2)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_valid(v1), .o_ready(rdy1),
        .o_bcd(bcd1), .o_overflow(of1), .o_blank(bl1), .o_valid(ov1), .i_ready(r1));
    bcd_convertor_pipe #(.DATA_WIDTH(16), .DIGITS(5)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d2), .i_valid(v2), .o_ready(rdy2),
        .o_bcd(bcd2), .o_overflow(of2), .o_blank(bl2), .o_valid(ov2), .i_ready(r2));

    typedef struct {
        int          inst;
        int          data;
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [4:0] exp_blank(input logic [4:0] b);
`ifdef BCD_BLANK_EN
        return b;
`else
        return 5'd0;
`endif
    endfunction

    function automatic logic get_valid(input int n);
        case (n) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction
    function automatic logic get_ready(input int n);
        case (n) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic get_ovf(input int n);
        case (n) 0: return of0; 1: return of1; default: return of2; endcase
    endfunction
    function automatic logic [19:0] get_bcd(input int n);
        case (n) 0: return {8'd0, bcd0}; 1: return {12'd0, bcd1}; default: return bcd2; endcase
    endfunction
    function automatic logic [4:0] get_blank(input int n);
        case (n) 0: return {2'd0, bl0}; 1: return {3'd0, bl1}; default: return bl2; endcase
    endfunction

    task automatic set_in(input int n, input logic v, input int d);
        case (n)
            0:       begin v0 = v; d0 = d[7:0];  end
            1:       begin v1 = v; d1 = d[7:0];  end
            default: begin v2 = v; d2 = d[15:0]; end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full handshake on instance n with i_ready held high
    task automatic do_conv(input int n, input int data, input logic [19:0] e_bcd,
                           input logic e_ovf, input logic [4:0] e_blank, input string name);
        int cyc;
        int lat;
        lat = (n == 2) ? 16 : 8;
        cyc = 0;
        while (!get_ready(n) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check({name, " ready_before"}, 32'(get_ready(n)), 32'd1);
        set_in(n, 1'b1, data);
        @(posedge clk); #1;
        set_in(n, 1'b0, 0);
        cyc = 0;
        while (!get_valid(n) && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " bcd"}, 32'(get_bcd(n)), 32'(e_bcd));
        check({name, " ovf"}, 32'(get_ovf(n)), 32'(e_ovf));
        check({name, " blank"}, 32'(get_blank(n)), 32'(exp_blank(e_blank)));
        @(posedge clk); #1;
        check({name, " valid_drop"}, 32'(get_valid(n)), 32'd0);
        check({name, " ready_back"}, 32'(get_ready(n)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] b2b_exp[3];
        int          b2b_in[3];
        int          idx_in;
        int          idx_out;
        int          last_cyc;
        logic        acc;

        vecs[0]  = '{0, 255,   20'h00255, 1'b0, 5'b00000};
        vecs[1]  = '{0, 0,     20'h00000, 1'b0, 5'b00110};
        vecs[2]  = '{0, 7,     20'h00007, 1'b0, 5'b00110};
        vecs[3]  = '{0, 42,    20'h00042, 1'b0, 5'b00100};
        vecs[4]  = '{0, 100,   20'h00100, 1'b0, 5'b00000};
        vecs[5]  = '{1, 99,    20'h00099, 1'b0, 5'b00000};
        vecs[6]  = '{1, 100,   20'h00000, 1'b1, 5'b00000};
        vecs[7]  = '{1, 255,   20'h00055, 1'b1, 5'b00000};
        vecs[8]  = '{1, 5,     20'h00005, 1'b0, 5'b00010};
        vecs[9]  = '{2, 65535, 20'h65535, 1'b0, 5'b00000};
        vecs[10] = '{2, 1,     20'h00001, 1'b0, 5'b11110};
        vecs[11] = '{2, 10,    20'h00010, 1'b0, 5'b11100};
        vecs[12] = '{2, 1000,  20'h01000, 1'b0, 5'b10000};

        rst_n = 1'b0;
        v0 = 0; v1 = 0; v2 = 0; d0 = 0; d1 = 0; d2 = 0;
        r0 = 1; r1 = 1; r2 = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int n = 0; n < 3; n++) begin
            check($sformatf("rst%0d ready", n), 32'(get_ready(n)), 32'd1);
            check($sformatf("rst%0d valid", n), 32'(get_valid(n)), 32'd0);
            check($sformatf("rst%0d bcd", n), 32'(get_bcd(n)), 32'd0);
            check($sformatf("rst%0d ovf", n), 32'(get_ovf(n)), 32'd0);
            check($sformatf("rst%0d blank", n), 32'(get_blank(n)), 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_conv(vecs[i].inst, vecs[i].data, vecs[i].bcd, vecs[i].ovf, vecs[i].blank,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: result held in DONE while i_ready is low, i_valid pulses ignored
        r0 = 1'b0;
        set_in(0, 1'b1, 200);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0);
        for (int c = 0; c < 40 && !ov0; c++) begin
            @(posedge clk); #1;
        end
        check("bp valid", 32'(ov0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            set_in(0, i[0] ? 1'b0 : 1'b1, 99);
            @(posedge clk); #1;
            check($sformatf("bp%0d valid", i), 32'(ov0), 32'd1);
            check($sformatf("bp%0d bcd", i), 32'(bcd0), 32'h200);
            check($sformatf("bp%0d ovf", i), 32'(of0), 32'd0);
            check($sformatf("bp%0d ready", i), 32'(rdy0), 32'd0);
        end
        set_in(0, 1'b0, 0);
        r0 = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", 32'(ov0), 32'd0);
        check("bp release ready", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        check("bp no_restart ready", 32'(rdy0), 32'd1);

        // Reset after the fourth shift aborts the conversion asynchronously
        set_in(0, 1'b1, 250);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst bcd", 32'(bcd0), 32'd0);
        check("mid_rst valid", 32'(ov0), 32'd0);
        check("mid_rst ovf", 32'(of0), 32'd0);
        check("mid_rst ready", 32'(rdy0), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst ready", 32'(rdy0), 32'd1);
        check("post_rst valid", 32'(ov0), 32'd0);
        do_conv(0, 123, 20'h00123, 1'b0, 5'b00000, "post_rst 123");

        // Back-to-back 1, 10, 100 on the 16/5 instance with i_valid held high
        b2b_in[0] = 1;  b2b_in[1] = 10; b2b_in[2] = 100;
        b2b_exp[0] = 20'h00001; b2b_exp[1] = 20'h00010; b2b_exp[2] = 20'h00100;
        idx_in = 0; idx_out = 0; last_cyc = 0;
        @(posedge clk); #1;
        set_in(2, 1'b1, b2b_in[0]);
        for (int c = 1; c <= 100 && idx_out < 3; c++) begin
            acc = rdy2 && v2;
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 3) set_in(2, 1'b1, b2b_in[idx_in]);
                else            set_in(2, 1'b0, 0);
            end
            if (ov2) begin
                check($sformatf("b2b%0d bcd", idx_out), 32'(bcd2), 32'(b2b_exp[idx_out]));
                if (idx_out > 0) check($sformatf("b2b%0d spacing", idx_out), 32'(c - last_cyc), 32'd18);
                last_cyc = c;
                idx_out++;
            end
        end
        set_in(2, 1'b0, 0);
        check("b2b results", 32'(idx_out), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
